// File: rtl/radix2_butterfly.sv
`default_nettype none
// ============================================================================
// Module   : radix2_butterfly
// Purpose  : 4-stage pipelined radix-2 DIT butterfly, X = A + B*W, Y = A - B*W,
//            with rounding, optional /2 scaling, saturation and global stall.
// Revision : 1.0 - initial release
// ============================================================================
module radix2_butterfly #(
    parameter int WL    = 16,
    parameter int FRAC  = 15,
    parameter int SCALE = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [WL-1:0] a_re,
    input  logic signed [WL-1:0] a_im,
    input  logic signed [WL-1:0] b_re,
    input  logic signed [WL-1:0] b_im,
    input  logic signed [WL-1:0] w_re,
    input  logic signed [WL-1:0] w_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WL-1:0] x_re,
    output logic signed [WL-1:0] x_im,
    output logic signed [WL-1:0] y_re,
    output logic signed [WL-1:0] y_im,
    output logic                 ovf
);

    localparam int c_PW = 2 * WL;
    localparam int c_TW = 2 * WL + 1;
    localparam logic signed [c_TW-1:0] c_RND = c_TW'(1) <<< (FRAC - 1);

    // Returns {saturated, value}: value fits WL iff all bits above the WL sign bit agree.
    function automatic logic [WL:0] f_sat(input logic [c_TW-1:0] v);
        logic [c_TW-WL:0] w_hi;
        w_hi = v[c_TW-1:WL-1];
        if ((&w_hi) || !(|w_hi))
            f_sat = {1'b0, v[WL-1:0]};
        else if (v[c_TW-1])
            f_sat = {1'b1, 1'b1, {(WL-1){1'b0}}};
        else
            f_sat = {1'b1, 1'b0, {(WL-1){1'b1}}};
    endfunction

    // Final combine; floor((s+1)/2) is evaluated as (s >>> 1) + s[0].
    function automatic logic [WL:0] f_comb(input logic [WL-1:0] a, input logic [WL-1:0] t,
                                           input logic sub);
        logic [WL:0] w_s;
        w_s = sub ? ({a[WL-1], a} - {t[WL-1], t}) : ({a[WL-1], a} + {t[WL-1], t});
        if (SCALE != 0)
            f_comb = {1'b0, w_s[WL:1] + {{(WL-1){1'b0}}, w_s[0]}};
        else
            f_comb = f_sat({{(c_TW-WL-1){w_s[WL]}}, w_s});
    endfunction

    logic                 w_adv;
    logic                 r_v1, r_v2, r_v3, r_v4;
    logic [WL-1:0]        r_a1_re, r_a1_im, r_a2_re, r_a2_im, r_a3_re, r_a3_im;
    logic [WL-1:0]        r_b1_re, r_b1_im, r_w1_re, r_w1_im;
    logic signed [c_PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic [WL-1:0]        r_t_re, r_t_im;

    logic signed [c_PW-1:0] w_b_re_x, w_b_im_x, w_w_re_x, w_w_im_x;
    logic signed [c_TW-1:0] w_t_re_full, w_t_im_full, w_t_re_rnd, w_t_im_rnd;
    logic [WL:0]          w_t_re_sat, w_t_im_sat;
    logic [WL:0]          w_x_re, w_x_im, w_y_re, w_y_im;

    assign w_adv     = out_ready | ~r_v4;
    assign in_ready  = w_adv;
    assign out_valid = r_v4;

    assign w_b_re_x = {{WL{r_b1_re[WL-1]}}, r_b1_re};
    assign w_b_im_x = {{WL{r_b1_im[WL-1]}}, r_b1_im};
    assign w_w_re_x = {{WL{r_w1_re[WL-1]}}, r_w1_re};
    assign w_w_im_x = {{WL{r_w1_im[WL-1]}}, r_w1_im};

    assign w_t_re_full = {r_p_rr[c_PW-1], r_p_rr} - {r_p_ii[c_PW-1], r_p_ii};
    assign w_t_im_full = {r_p_ri[c_PW-1], r_p_ri} + {r_p_ir[c_PW-1], r_p_ir};
    assign w_t_re_rnd  = (w_t_re_full + c_RND) >>> FRAC;
    assign w_t_im_rnd  = (w_t_im_full + c_RND) >>> FRAC;
    assign w_t_re_sat  = f_sat(w_t_re_rnd);
    assign w_t_im_sat  = f_sat(w_t_im_rnd);

    assign w_x_re = f_comb(r_a3_re, r_t_re, 1'b0);
    assign w_x_im = f_comb(r_a3_im, r_t_im, 1'b0);
    assign w_y_re = f_comb(r_a3_re, r_t_re, 1'b1);
    assign w_y_im = f_comb(r_a3_im, r_t_im, 1'b1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_v4    <= 1'b0;
            r_a1_re <= '0;
            r_a1_im <= '0;
            r_b1_re <= '0;
            r_b1_im <= '0;
            r_w1_re <= '0;
            r_w1_im <= '0;
            r_a2_re <= '0;
            r_a2_im <= '0;
            r_p_rr  <= '0;
            r_p_ii  <= '0;
            r_p_ri  <= '0;
            r_p_ir  <= '0;
            r_a3_re <= '0;
            r_a3_im <= '0;
            r_t_re  <= '0;
            r_t_im  <= '0;
            x_re    <= '0;
            x_im    <= '0;
            y_re    <= '0;
            y_im    <= '0;
            ovf     <= 1'b0;
        end else if (w_adv) begin
            r_v1    <= in_valid;
            r_a1_re <= a_re;
            r_a1_im <= a_im;
            r_b1_re <= b_re;
            r_b1_im <= b_im;
            r_w1_re <= w_re;
            r_w1_im <= w_im;

            r_v2    <= r_v1;
            r_a2_re <= r_a1_re;
            r_a2_im <= r_a1_im;
            r_p_rr  <= w_b_re_x * w_w_re_x;
            r_p_ii  <= w_b_im_x * w_w_im_x;
            r_p_ri  <= w_b_re_x * w_w_im_x;
            r_p_ir  <= w_b_im_x * w_w_re_x;

            r_v3    <= r_v2;
            r_a3_re <= r_a2_re;
            r_a3_im <= r_a2_im;
            r_t_re  <= w_t_re_sat[WL-1:0];
            r_t_im  <= w_t_im_sat[WL-1:0];

            r_v4    <= r_v3;
            x_re    <= w_x_re[WL-1:0];
            x_im    <= w_x_im[WL-1:0];
            y_re    <= w_y_re[WL-1:0];
            y_im    <= w_y_im[WL-1:0];

            // Only beats actually occupying the stage may raise the sticky flag.
            ovf <= ovf
                 | (r_v2 & (w_t_re_sat[WL] | w_t_im_sat[WL]))
                 | (r_v3 & (w_x_re[WL] | w_x_im[WL] | w_y_re[WL] | w_y_im[WL]));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_radix2_butterfly.sv
`default_nettype none
// ============================================================================
// Module   : tb_radix2_butterfly
// Purpose  : Self-checking bench for radix2_butterfly (SCALE=1 and SCALE=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_radix2_butterfly;

    localparam int WL   = 16;
    localparam int FRAC = 15;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [WL-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;

    logic in_ready1, out_valid1, ovf1, in_ready0, out_valid0, ovf0;
    logic signed [WL-1:0] x_re1, x_im1, y_re1, y_im1, x_re0, x_im0, y_re0, y_im0;

    always #5 CLK = ~CLK;

    radix2_butterfly #(.WL(WL), .FRAC(FRAC), .SCALE(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready1),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid1), .out_ready(out_ready),
        .x_re(x_re1), .x_im(x_im1), .y_re(y_re1), .y_im(y_im1), .ovf(ovf1)
    );

    radix2_butterfly #(.WL(WL), .FRAC(FRAC), .SCALE(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready0),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid0), .out_ready(out_ready),
        .x_re(x_re0), .x_im(x_im0), .y_re(y_re0), .y_im(y_im0), .ovf(ovf0)
    );

    typedef struct packed {
        logic [63:0] r;
        logic [31:0] acc;
    } exp_t;

    exp_t        q1[$], q0[$];
    int          checks = 0, errors = 0, cyc = 0, ndel1 = 0;
    bit          bp = 0, lat_chk = 0, accepted = 0;
    bit          hold1 = 0, hold0 = 0, cur_s1 = 0, cur_s0 = 0, exp_ovf1 = 0, exp_ovf0 = 0;
    logic [63:0] held1 = '0, held0 = '0, cur1 = '0, cur0 = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint clip(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [63:0] pack4(input longint xr, xi, yr, yi);
        return {16'(xr), 16'(xi), 16'(yr), 16'(yi)};
    endfunction

    function automatic int rnd16();
        return int'($signed(16'($urandom)));
    endfunction

    // Reference: exact integer arithmetic of the butterfly for both scaling modes.
    task automatic model(input longint ar, ai, br, bi, wr, wi,
                         output logic [63:0] e1, e0, output bit s1, s0);
        longint half, tr, ti, ctr, cti, sxr, sxi, syr, syi;
        half = longint'(1) <<< (FRAC - 1);
        tr   = (br * wr - bi * wi + half) >>> FRAC;
        ti   = (br * wi + bi * wr + half) >>> FRAC;
        ctr  = clip(tr);
        cti  = clip(ti);
        sxr  = ar + ctr;
        syr  = ar - ctr;
        sxi  = ai + cti;
        syi  = ai - cti;
        e1   = pack4((sxr + 1) >>> 1, (sxi + 1) >>> 1, (syr + 1) >>> 1, (syi + 1) >>> 1);
        s1   = (ctr != tr) || (cti != ti);
        e0   = pack4(clip(sxr), clip(sxi), clip(syr), clip(syi));
        s0   = s1 || (clip(sxr) != sxr) || (clip(sxi) != sxi)
                  || (clip(syr) != syr) || (clip(syi) != syi);
    endtask

    task automatic tick();
        logic [63:0] o1, o0;
        exp_t e;
        @(negedge CLK);
        o1 = {x_re1, x_im1, y_re1, y_im1};
        o0 = {x_re0, x_im0, y_re0, y_im0};
        check("in_ready1", in_ready1, !(out_valid1 && !out_ready));
        check("in_ready0", in_ready0, !(out_valid0 && !out_ready));
        if (hold1) begin
            check("stall_valid1", out_valid1, 1);
            check("stall_data1", o1, held1);
        end
        if (hold0) begin
            check("stall_valid0", out_valid0, 1);
            check("stall_data0", o0, held0);
        end
        if (out_valid1 && out_ready) begin
            if (q1.size() == 0) check("spurious1", out_valid1, 0);
            else begin
                e = q1.pop_front();
                ndel1++;
                check("out1", o1, e.r);
                if (lat_chk) check("latency1", cyc, e.acc + 4);
            end
        end
        if (out_valid0 && out_ready) begin
            if (q0.size() == 0) check("spurious0", out_valid0, 0);
            else begin
                e = q0.pop_front();
                check("out0", o0, e.r);
                if (lat_chk) check("latency0", cyc, e.acc + 4);
            end
        end
        hold1 = out_valid1 && !out_ready && !RST;
        hold0 = out_valid0 && !out_ready && !RST;
        held1 = o1;
        held0 = o0;
        if (in_valid && in_ready1 && !RST) begin
            e.r = cur1; e.acc = cyc;
            q1.push_back(e);
            exp_ovf1 |= cur_s1;
            accepted = 1;
        end
        if (in_valid && in_ready0 && !RST) begin
            e.r = cur0; e.acc = cyc;
            q0.push_back(e);
            exp_ovf0 |= cur_s0;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int ar, ai, br, bi, wr, wi,
                        input bit use_exp, input logic [63:0] d1, d0);
        logic [63:0] m1, m0;
        bit s1, s0;
        model(ar, ai, br, bi, wr, wi, m1, m0, s1, s0);
        cur1 = use_exp ? d1 : m1;
        cur0 = use_exp ? d0 : m0;
        cur_s1 = s1;
        cur_s0 = s0;
        a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi); w_re = 16'(wr); w_im = 16'(wi);
        in_valid = 1'b1;
        accepted = 0;
        for (int n = 0; n < 200 && !accepted; n++) tick();
        check("accepted", accepted, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 400 && (q1.size() != 0 || q0.size() != 0); n++) tick();
        check(tag, q1.size() + q0.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        RST = 1'b0;
        check("rst_valid1", out_valid1, 0);
        check("rst_valid0", out_valid0, 0);
        check("rst_ovf1", ovf1, 0);
        check("rst_ovf0", ovf0, 0);
        check("rst_data1", {x_re1, x_im1, y_re1, y_im1}, 0);
        check("rst_data0", {x_re0, x_im0, y_re0, y_im0}, 0);
        check("rst_in_ready", in_ready1, 1);

        lat_chk = 1;
        send(1000, 0, 2000, 0, 32767, 0, 1, pack4(1500, 0, -500, 0), pack4(3000, 0, -1000, 0));
        drain("drain_ident");
        send(0, 0, 2000, 0, 0, -32768, 1, pack4(0, -1000, 0, 1000), pack4(0, -2000, 0, 2000));
        drain("drain_negj");
        send(30000, 0, 30000, 0, 32767, 0, 1, pack4(30000, 0, 1, 0), pack4(32767, 0, 1, 0));
        drain("drain_sat");
        check("sat_ovf0", ovf0, 1);
        check("sat_ovf1", ovf1, exp_ovf1);

        // Random beats with pseudo-random downstream backpressure.
        lat_chk = 0;
        bp = 1;
        for (int i = 0; i < 8; i++) begin
            send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 0, '0, '0);
            if ($urandom_range(0, 2) == 0) tick();
        end
        drain("drain_bp");
        bp = 0;
        out_ready = 1'b1;
        check("bp_ovf1", ovf1, exp_ovf1);
        check("bp_ovf0_sticky", ovf0, exp_ovf0);

        // Reset with three beats in flight; a beat offered during reset must be dropped.
        lat_chk = 1;
        for (int i = 0; i < 3; i++)
            send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 0, '0, '0);
        RST = 1'b1;
        in_valid = 1'b1;
        q1.delete();
        q0.delete();
        hold1 = 0;
        hold0 = 0;
        repeat (2) tick();
        RST = 1'b0;
        in_valid = 1'b0;
        exp_ovf1 = 0;
        exp_ovf0 = 0;
        check("mid_rst_valid1", out_valid1, 0);
        check("mid_rst_ovf0", ovf0, 0);
        check("mid_rst_ovf1", ovf1, 0);
        check("mid_rst_data1", {x_re1, x_im1, y_re1, y_im1}, 0);
        check("mid_rst_data0", {x_re0, x_im0, y_re0, y_im0}, 0);
        repeat (8) tick();
        check("post_rst_valid0", out_valid0, 0);

        // Back-to-back stream at full rate.
        ndel1 = 0;
        for (int i = 0; i < 64; i++)
            send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 0, '0, '0);
        drain("drain_tp");
        check("tp_count1", ndel1, 64);
        check("tp_ovf1", ovf1, exp_ovf1);
        check("tp_ovf0", ovf0, exp_ovf0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
